// File: rtl/gpio_pkg.sv
// Shared definitions for the GPIO controller: register indices and the byte-strobe merge helper.
package gpio_pkg;

  localparam logic [31:0] REG_MODE    = 32'd0;
  localparam logic [31:0] REG_DIR     = 32'd1;
  localparam logic [31:0] REG_OUTPUT  = 32'd2;
  localparam logic [31:0] REG_INPUT   = 32'd3;
  localparam logic [31:0] REG_TR_TYPE = 32'd4;
  localparam logic [31:0] REG_TR_LVL0 = 32'd5;
  localparam logic [31:0] REG_TR_LVL1 = 32'd6;
  localparam logic [31:0] REG_TR_STAT = 32'd7;
  localparam logic [31:0] REG_IRQ_EN  = 32'd8;
  localparam logic [31:0] REG_LAST    = REG_IRQ_EN;

  // One byte lane of a strobed write: take the new byte only when its strobe is set.
  function automatic logic [7:0] strb_merge(input logic [7:0] old_b,
                                            input logic [7:0] new_b,
                                            input logic       en);
    return en ? new_b : old_b;
  endfunction

endpackage

// File: rtl/gpio_sync.sv
// Multi-stage input synchronizer with a trailing history flop for rise/fall detection.
module gpio_sync #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk_in1,
  input  logic             reset,
  input  logic [WIDTH-1:0] i_async,
  output logic [WIDTH-1:0] o_sync,
  output logic [WIDTH-1:0] o_rise,
  output logic [WIDTH-1:0] o_fall
);

  logic [WIDTH-1:0] r_chain [STAGES];
  logic [WIDTH-1:0] r_prev;

  always_ff @(posedge clk_in1) begin
    if (reset) r_chain[0] <= '0;
    else       r_chain[0] <= i_async;
  end

  for (genvar gi = 1; gi < STAGES; gi++) begin : g_stage
    always_ff @(posedge clk_in1) begin
      if (reset) r_chain[gi] <= '0;
      else       r_chain[gi] <= r_chain[gi-1];
    end
  end

  always_ff @(posedge clk_in1) begin
    if (reset) r_prev <= '0;
    else       r_prev <= r_chain[STAGES-1];
  end

  assign o_sync = r_chain[STAGES-1];
  assign o_rise = o_sync & ~r_prev;
  assign o_fall = ~o_sync & r_prev;

endmodule

// File: rtl/gpio_ctrl.sv
// APB3 GPIO controller: per-pin direction, push-pull/open-drain drive, sticky
// level/edge trigger status and one aggregated interrupt.
module gpio_ctrl
  import gpio_pkg::*;
#(
  parameter int GPIO_PINS  = 32,
  parameter int PADDR_SIZE = 4,
  parameter int STAGES     = 2
) (
  input  logic                   clk_in1,
  input  logic                   reset,
  input  logic [PADDR_SIZE-1:0]  paddr,
  input  logic                   psel,
  input  logic                   penable,
  input  logic                   pwrite,
  input  logic [GPIO_PINS-1:0]   pwdata,
  input  logic [GPIO_PINS/8-1:0] pstrb,
  output logic [GPIO_PINS-1:0]   prdata,
  output logic                   pready,
  output logic                   pslverr,
  input  logic [GPIO_PINS-1:0]   gpio_i,
  output logic [GPIO_PINS-1:0]   gpio_of,
  output logic [GPIO_PINS-1:0]   gpio_oef,
  output logic                   irq
);

  localparam int NBYTES = GPIO_PINS / 8;

  logic [GPIO_PINS-1:0] r_mode, r_dir, r_out, r_tr_type, r_lvl0, r_lvl1, r_stat, r_irq_en;
  logic                 r_irq;

  logic [GPIO_PINS-1:0] w_sync, w_rise, w_fall, w_trig;
  logic [GPIO_PINS-1:0] w_regval, w_merged, w_w1c_data, w_w1c_mask;
  logic [31:0]          w_idx;
  logic                 w_access, w_err, w_wr, w_rd;

  gpio_sync #(.WIDTH(GPIO_PINS), .STAGES(STAGES)) u_sync (
    .clk_in1 (clk_in1),
    .reset   (reset),
    .i_async (gpio_i),
    .o_sync  (w_sync),
    .o_rise  (w_rise),
    .o_fall  (w_fall)
  );

  assign w_idx    = 32'(paddr);
  assign w_access = psel & penable;
  assign w_err    = w_access & ((w_idx > REG_LAST) | (pwrite & (w_idx == REG_INPUT)));
  assign w_wr     = w_access & pwrite & ~w_err;
  assign w_rd     = w_access & ~pwrite & ~w_err;

  always_comb begin
    w_regval = '0;
    case (w_idx)
      REG_MODE:    w_regval = r_mode;
      REG_DIR:     w_regval = r_dir;
      REG_OUTPUT:  w_regval = r_out;
      REG_INPUT:   w_regval = w_sync;
      REG_TR_TYPE: w_regval = r_tr_type;
      REG_TR_LVL0: w_regval = r_lvl0;
      REG_TR_LVL1: w_regval = r_lvl1;
      REG_TR_STAT: w_regval = r_stat;
      REG_IRQ_EN:  w_regval = r_irq_en;
      default:     w_regval = '0;
    endcase
  end

  // Merged write value keeps unstrobed lanes of the addressed register; the
  // W1C mask treats unstrobed lanes as zeros so they clear nothing.
  for (genvar gi = 0; gi < NBYTES; gi++) begin : g_lane
    assign w_merged[gi*8 +: 8]   = strb_merge(w_regval[gi*8 +: 8], pwdata[gi*8 +: 8], pstrb[gi]);
    assign w_w1c_data[gi*8 +: 8] = strb_merge(8'h00, pwdata[gi*8 +: 8], pstrb[gi]);
  end

  assign w_w1c_mask = (w_wr && (w_idx == REG_TR_STAT)) ? w_w1c_data : '0;

  assign w_trig = (r_tr_type  & ((r_lvl1 & w_rise) | (r_lvl0 & w_fall)))
                | (~r_tr_type & ((r_lvl1 & w_sync) | (r_lvl0 & ~w_sync)));

  always_ff @(posedge clk_in1) begin
    if (reset) begin
      r_mode    <= '0;
      r_dir     <= '0;
      r_out     <= '0;
      r_tr_type <= '0;
      r_lvl0    <= '0;
      r_lvl1    <= '0;
      r_stat    <= '0;
      r_irq_en  <= '0;
      r_irq     <= 1'b0;
    end else begin
      // New triggers override a same-cycle clear so no event is lost.
      r_stat <= (r_stat & ~w_w1c_mask) | w_trig;
      r_irq  <= |(r_stat & r_irq_en);
      if (w_wr) begin
        case (w_idx)
          REG_MODE:    r_mode    <= w_merged;
          REG_DIR:     r_dir     <= w_merged;
          REG_OUTPUT:  r_out     <= w_merged;
          REG_TR_TYPE: r_tr_type <= w_merged;
          REG_TR_LVL0: r_lvl0    <= w_merged;
          REG_TR_LVL1: r_lvl1    <= w_merged;
          REG_IRQ_EN:  r_irq_en  <= w_merged;
          default:     ;
        endcase
      end
    end
  end

  assign gpio_of  = r_out & ~r_mode;
  assign gpio_oef = r_dir & ~(r_mode & r_out);
  assign prdata   = w_rd ? w_regval : '0;
  assign pready   = 1'b1;
  assign pslverr  = w_err;
  assign irq      = r_irq;

endmodule

// File: tb/tb_gpio_ctrl.sv
// Directed self-checking bench for gpio_ctrl with hand-computed expectations.
module tb_gpio_ctrl;

  logic        clk_in1 = 1'b0;
  logic        reset;
  logic [3:0]  paddr;
  logic        psel, penable, pwrite;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic [31:0] prdata;
  logic        pready, pslverr;
  logic [31:0] gpio_i, gpio_of, gpio_oef;
  logic        irq;

  int checks = 0;
  int errors = 0;
  logic [31:0] rd;
  logic        err;

  gpio_ctrl #(.GPIO_PINS(32), .PADDR_SIZE(4), .STAGES(2)) dut (
    .clk_in1  (clk_in1),
    .reset    (reset),
    .paddr    (paddr),
    .psel     (psel),
    .penable  (penable),
    .pwrite   (pwrite),
    .pwdata   (pwdata),
    .pstrb    (pstrb),
    .prdata   (prdata),
    .pready   (pready),
    .pslverr  (pslverr),
    .gpio_i   (gpio_i),
    .gpio_of  (gpio_of),
    .gpio_oef (gpio_oef),
    .irq      (irq)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apb_write(input logic [3:0] a, input logic [31:0] d, input logic [3:0] s,
                           output logic e);
    @(negedge clk_in1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = a; pwdata = d; pstrb = s;
    @(negedge clk_in1);
    penable = 1'b1;
    #1 e = pslverr;
    @(posedge clk_in1);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
  endtask

  task automatic apb_read(input logic [3:0] a, output logic [31:0] d, output logic e);
    @(negedge clk_in1);
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = a;
    @(negedge clk_in1);
    penable = 1'b1;
    #1 d = prdata; e = pslverr;
    @(posedge clk_in1);
    #1 psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    reset = 1'b1; psel = 1'b0; penable = 1'b0; pwrite = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0; gpio_i = '0;
    repeat (6) @(posedge clk_in1);
    @(negedge clk_in1);
    reset = 1'b0;

    // Reset state
    check("rst_oef", gpio_oef, 32'h0);
    check("rst_of", gpio_of, 32'h0);
    check("rst_irq", {31'b0, irq}, 32'h0);
    check("pready", {31'b0, pready}, 32'h1);
    check("idle_prdata", prdata, 32'h0);
    for (int i = 0; i <= 8; i++) begin
      apb_read(4'(i), rd, err);
      check($sformatf("rst_reg%0d", i), rd, 32'h0);
    end
    check("rd_no_err", {31'b0, err}, 32'h0);

    // Push-pull output
    apb_write(4'd1, 32'hFFFF_FFFF, 4'hF, err);
    apb_write(4'd2, 32'hA5A5_5A5A, 4'hF, err);
    check("pp_oef", gpio_oef, 32'hFFFF_FFFF);
    check("pp_of", gpio_of, 32'hA5A5_5A5A);
    apb_read(4'd2, rd, err);
    check("pp_out_rd", rd, 32'hA5A5_5A5A);

    // Open-drain on the low byte
    apb_write(4'd0, 32'h0000_00FF, 4'hF, err);
    apb_write(4'd1, 32'h0000_00FF, 4'hF, err);
    apb_write(4'd2, 32'h0000_000F, 4'hF, err);
    check("od_of", gpio_of, 32'h0000_0000);
    check("od_oef", gpio_oef, 32'h0000_00F0);

    // Byte strobes
    apb_write(4'd2, 32'h0, 4'hF, err);
    apb_write(4'd2, 32'h1122_3344, 4'b0010, err);
    apb_read(4'd2, rd, err);
    check("strb_out", rd, 32'h0000_3300);

    // Synchronizer latency with a held read of INPUT
    @(negedge clk_in1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b0; paddr = 4'd3; gpio_i = 32'h1;
    @(posedge clk_in1);
    #1 check("sync_lat1", prdata, 32'h0);
    @(posedge clk_in1);
    #1 check("sync_lat2", prdata, 32'h1);
    psel = 1'b0; penable = 1'b0;

    // Rising-edge trigger on pin 0
    apb_write(4'd4, 32'h1, 4'hF, err);
    apb_write(4'd6, 32'h1, 4'hF, err);
    apb_write(4'd8, 32'h1, 4'hF, err);
    apb_read(4'd7, rd, err);
    check("edge_stat_idle", rd, 32'h0);
    @(negedge clk_in1);
    gpio_i = 32'h0;
    repeat (4) @(posedge clk_in1);
    apb_read(4'd7, rd, err);
    check("edge_fall_ignored", rd, 32'h0);
    @(negedge clk_in1);
    gpio_i = 32'h1;
    repeat (3) @(posedge clk_in1);
    #1 check("edge_irq_not_yet", {31'b0, irq}, 32'h0);
    @(posedge clk_in1);
    #1 check("edge_irq", {31'b0, irq}, 32'h1);
    apb_read(4'd7, rd, err);
    check("edge_stat", rd, 32'h1);

    // W1C clears; steady high does not re-trigger
    apb_write(4'd7, 32'h1, 4'hF, err);
    @(posedge clk_in1);
    #1 check("w1c_irq", {31'b0, irq}, 32'h0);
    apb_read(4'd7, rd, err);
    check("w1c_stat", rd, 32'h0);
    repeat (4) @(posedge clk_in1);
    apb_read(4'd7, rd, err);
    check("edge_no_retrig", rd, 32'h0);

    // Error responses
    apb_write(4'd3, 32'hFFFF_FFFF, 4'hF, err);
    check("err_wr_input", {31'b0, err}, 32'h1);
    apb_read(4'd3, rd, err);
    check("input_rd", rd, 32'h1);
    check("input_rd_ok", {31'b0, err}, 32'h0);
    apb_write(4'd12, 32'hFFFF_FFFF, 4'hF, err);
    check("err_wr_12", {31'b0, err}, 32'h1);
    apb_read(4'd12, rd, err);
    check("err_rd_12_data", rd, 32'h0);
    check("err_rd_12", {31'b0, err}, 32'h1);
    apb_read(4'd4, rd, err);
    check("err_trtype_kept", rd, 32'h1);
    apb_read(4'd2, rd, err);
    check("err_out_kept", rd, 32'h0000_3300);
    apb_read(4'd8, rd, err);
    check("irqen_rd", rd, 32'h1);
    check("irqen_rd_ok", {31'b0, err}, 32'h0);

    // Level-low trigger on pin 4 (pin held low)
    apb_write(4'd5, 32'h0000_0010, 4'hF, err);
    repeat (2) @(posedge clk_in1);
    apb_read(4'd7, rd, err);
    check("lvl_stat", rd, 32'h0000_0010);
    apb_write(4'd7, 32'h0000_0010, 4'hF, err);
    apb_read(4'd7, rd, err);
    check("lvl_after_w1c", rd, 32'h0000_0010);
    check("lvl_irq_masked", {31'b0, irq}, 32'h0);
    apb_write(4'd8, 32'h0000_0011, 4'hF, err);
    @(posedge clk_in1);
    #1 check("lvl_irq", {31'b0, irq}, 32'h1);

    // Reset during an access phase
    @(negedge clk_in1);
    psel = 1'b1; penable = 1'b1; pwrite = 1'b1; paddr = 4'd2;
    pwdata = 32'hFFFF_FFFF; pstrb = 4'hF; reset = 1'b1;
    @(posedge clk_in1);
    #1 psel = 1'b0; penable = 1'b0; pwrite = 1'b0; reset = 1'b0;
    check("midrst_oef", gpio_oef, 32'h0);
    check("midrst_of", gpio_of, 32'h0);
    apb_read(4'd2, rd, err);
    check("midrst_out", rd, 32'h0);
    check("midrst_irq", {31'b0, irq}, 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/gpio_ctrl.md
Name: gpio_ctrl

Overview:
- APB3 slave GPIO controller with per-pin direction, push-pull/open-drain mode and output data.
- Input pins pass through a synchronizer; per-pin level or edge triggers set sticky status bits.
- Drives one aggregated interrupt.
- Sits on the peripheral APB bus between the CPU and the chip-level pad ring.

Parameters:
GPIO_PINS, 32, number of pins and APB data width; must be a multiple of 8.
PADDR_SIZE, 4, APB address width; PADDR is a word index.
STAGES, 2, input synchronizer depth; must be ≥2.

Ports:
clk_in1  in  1  system clock; everything is in this domain.
reset  in  1  synchronous, active-high reset.
paddr  in  PADDR_SIZE  register index.
psel  in  1  APB select.
penable  in  1  APB access phase.
pwrite  in  1  1 = write.
pwdata  in  GPIO_PINS  write data.
pstrb  in  GPIO_PINS/8  byte write strobes.
prdata  out  GPIO_PINS  read data.
pready  out  1  tied to 1.
pslverr  out  1  error response.
gpio_i  in  GPIO_PINS  asynchronous pad inputs.
gpio_of  out  GPIO_PINS  pad output value.
gpio_oef  out  GPIO_PINS  pad output enable, 1 = drive.
irq  out  1  interrupt.

Behaviour:
- Clocking and reset:
  - Only clock is clk_in1; reset is synchronous and active-high.
  - Every register and synchronizer flop resets to 0, so gpio_of=0, gpio_oef=0, irq=0 and prdata=0 after reset.
- APB transfers:
  - Zero wait states; pready is always 1.
  - Write commits on the rising edge where psel & penable & pwrite; only byte lanes with the pstrb bit set are updated.
  - Read: prdata is combinational from paddr while psel & penable & ~pwrite; otherwise prdata = 0.
- Register map (index = paddr):
  - 0 MODE: 1 = open-drain, 0 = push-pull.
  - 1 DIRECTION: 1 = output.
  - 2 OUTPUT.
  - 3 INPUT: read-only synchronized pins.
  - 4 TR_TYPE: 0 = level, 1 = edge.
  - 5 TR_LVL0: level mode = trigger while low; edge mode = falling edge.
  - 6 TR_LVL1: level mode = trigger while high; edge mode = rising edge.
  - 7 TR_STAT: sticky status, write-1-to-clear.
  - 8 IRQ_EN.
- Error responses:
  - pslverr=1 in the access phase for paddr > 8, or for a write to INPUT.
  - Such writes change no state; such reads return 0.
- Pad drive:
  - Push-pull pin: gpio_of = OUTPUT, gpio_oef = DIRECTION.
  - Open-drain pin: gpio_of = 0, gpio_oef = DIRECTION & ~OUTPUT.
  - Both outputs are combinational from the registers, so pads change the cycle after the write edge.
- Synchronizer: gpio_i passes through a STAGES-deep flop chain; INPUT shows the last stage, i.e. STAGES cycles of latency.
- Edge detection:
  - One extra flop holds the previous synchronized value.
  - Rise = sync & ~prev; fall = ~sync & prev.
- Trigger per pin:
  - Edge mode: (TR_LVL1 & rise) | (TR_LVL0 & fall).
  - Level mode: (TR_LVL1 & sync) | (TR_LVL0 & ~sync).
- TR_STAT update: next = (stat & ~w1c_mask) | trigger.
  - A set in the same cycle as a clear wins, so no event is lost.
  - Level triggers re-set TR_STAT every cycle while the condition holds.
- irq = |(TR_STAT & IRQ_EN), registered, so it asserts 1 cycle after TR_STAT sets.
- Triggers are evaluated regardless of DIRECTION, so output pins read back through the pads can interrupt.
- Reset mid-transfer aborts the transfer; no register is written.

Decomposition:
- Package gpio_pkg holds the register index localparams (MODE..IRQ_EN) and a function applying byte strobes to a word.
- One sub-module, gpio_sync: parameterized STAGES synchronizer plus the prev flop; outputs sync, rise, fall.

Test Plan:
- Reset for 6 cycles -> gpio_oef=0, gpio_of=0, irq=0; reading each of registers 0-8 returns 0.
- Push-pull output: write DIRECTION=0xFFFF_FFFF, then OUTPUT=0xA5A5_5A5A -> gpio_oef=0xFFFF_FFFF and gpio_of=0xA5A5_5A5A from the next cycle; OUTPUT reads back 0xA5A5_5A5A.
- Open-drain: MODE=0x0000_00FF, DIRECTION=0xFF, OUTPUT=0x0F -> gpio_of=0x00 and gpio_oef low byte=0xF0.
- Byte strobes: write OUTPUT=0x1122_3344 with pstrb=4'b0010 on a zeroed register -> OUTPUT reads 0x0000_3300.
- Input and edge interrupt: gpio_i=0x0000_0001 -> INPUT reads 1 after 2 cycles.
  - With TR_TYPE[0]=1, TR_LVL1[0]=1, IRQ_EN[0]=1, a 0→1 transition on pin 0 -> TR_STAT=1 and irq=1.
  - Writing TR_STAT=1 clears both; holding the pin high does not re-trigger.
- Errors and level trigger:
  - Write to paddr=3 or paddr=12 -> pslverr=1, no state change.
  - Level-low trigger on pin 4 with the pin held low -> TR_STAT[4] stays 1 even immediately after a W1C.
